agu_bitrev_gen: RTL and testbench
=================================

# agu_bitrev_gen

Parametrised NTT address generation unit. It walks a base index `j` across a run of 2^`cfg_log_n_i` indices, `LANES` indices per beat. For each index it produces the bit-reversed, radix-scaled butterfly member addresses. It feeds the memory-bank address path of the NTT datapath and supersedes the fixed 8-lane, fixed-size stage AGUs. Unlike those, it adds runtime transform size, a ready/valid output with backpressure, and an explicit last/done indication.

## Interface
Parameters:
- `D_WIDTH`, 12: width of each order (address) word.
- `LANES`, 8: indices per beat; power of 2, ≥1.
- `IDX_BITS_MAX`, 9: maximum bit-reverse width; ≥ log2(`LANES`).
- `RADIX_SHIFT`, 1: log2 of butterfly radix; R = 1<<`RADIX_SHIFT` members per index.
- Elaboration error if `IDX_BITS_MAX` + `RADIX_SHIFT` > `D_WIDTH`.

Ports:
- `clk`: input, 1 bit. Single clock; all state on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `start_i`: input, 1 bit. Run request, sampled only in IDLE.
- `cfg_log_n_i`: input, $clog2(`IDX_BITS_MAX`+1) bits. log2 of run length; latched on start.
- `nat_order_i`: input, 1 bit. Only present with `AGU_NAT_ORDER_EN`; latched on start.
- `busy_o`: output, 1 bit. High in RUN and DONE.
- `out_valid_o`: output, 1 bit. Beat valid.
- `out_ready_i`: input, 1 bit. Consumer accepts the beat.
- `out_j_o`: output, `IDX_BITS_MAX` bits. Base index `j` of the current beat.
- `out_last_o`: output, 1 bit. Current beat is the final beat of the run.
- `order_o`: output, `LANES`*R*`D_WIDTH` bits. Word [i*R+m] = (rev(j+i) << `RADIX_SHIFT`) + m.
- `done_o`: output, 1 bit. One-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start_i`=1:
  - Latch L = clamp(`cfg_log_n_i`, log2(`LANES`), `IDX_BITS_MAX`).
  - Set `j` = 0 and load the first beat.
- In RUN, `out_valid_o`=1. A beat is accepted when `out_valid_o` && `out_ready_i`.
  - On accept, if not last: `j` += `LANES` and the next beat loads.
  - On accept, if last: go to DONE.
- Beats per run = 2^L / `LANES`. The last beat has `j` = 2^L − `LANES`. `j` never exceeds 2^L − 1, so there is no overshoot beat.
- DONE lasts exactly one cycle: `done_o`=1, then back to IDLE.
- rev(x) = the low L bits of x reversed; bits above L are zero. Shift and add are computed at `D_WIDTH` with no truncation possible, given the parameter check.
- `start_i` is ignored outside IDLE. The latched config is stable for the whole run.
- Outputs are registered: `order_o`, `out_j_o` and `out_last_o` change only on load or accept.

## Timing
- Reset (`rst`=0, asynchronous), all outputs zero:
  - `busy_o`, `out_valid_o`, `out_last_o`, `done_o` = 0.
  - `out_j_o` = 0, `order_o` = 0.
  - State = IDLE.
- Start sampled at edge t → `out_valid_o`=1 with the `j`=0 beat from cycle t+1.
- Throughput is 1 beat per cycle while `out_ready_i`=1.
- With `out_ready_i`=0 the beat holds: all outputs are bit-stable and `j` does not advance.
- Last beat accepted at edge u:
  - `done_o`=1 and `out_valid_o`=0 in cycle u+1.
  - IDLE at u+2; the earliest next start is sampled at edge u+2.
- Single-beat run (2^L = `LANES`): `out_last_o`=1 on the first beat.
- Reset asserted mid-run: immediate return to IDLE with all outputs zero. No `done_o` is produced. After release, the block waits for a new `start_i`.

## Configuration
- `AGU_NAT_ORDER_EN` defined:
  - Port `nat_order_i` exists and is latched at start.
  - When latched high, rev(x) is replaced by x (natural order). Scaling and +m are unchanged.
- `AGU_NAT_ORDER_EN` undefined: the port is absent and bit-reversed order is always used.

## Test plan
- Bit-reverse, single beat: `LANES`=8, `RADIX_SHIFT`=1, `cfg_log_n_i`=3, ready held high.
  - Required: exactly one beat with `out_last_o`=1.
  - `order_o` lane pairs: (0,1), (8,9), (4,5), (12,13), (2,3), (10,11), (6,7), (14,15).
  - `done_o` pulses in the next cycle.
- Two-beat run: `cfg_log_n_i`=4.
  - Beat0 `out_j_o`=0, lane1 = (16,17).
  - Beat1 `out_j_o`=8, lane0 = (2,3), `out_last_o`=1.
- Backpressure: drop `out_ready_i` for 3 cycles mid-run.
  - Required: outputs bit-stable, no beat skipped or duplicated, beat count unchanged.
- Reset and start rules:
  - Assert `rst`=0 during beat 1 → all outputs 0 and no `done_o`.
  - `start_i` pulsed during RUN → ignored.
  - `cfg_log_n_i`=1 → clamped to 3.
- With `AGU_NAT_ORDER_EN`, `nat_order_i`=1, `cfg_log_n_i`=3:
  - Lanes (0,1), (2,3), (4,5), …, (14,15).
  - Without the macro, the same stimulus gives the bit-reversed result above.

Source files
------------

// File: rtl/agu_bitrev_gen.sv
// agu_bitrev_gen: NTT address generator emitting bit-reversed, radix-scaled butterfly addresses; define AGU_NAT_ORDER_EN to add the nat_order_i natural-order option
module agu_bitrev_gen #(
  parameter int D_WIDTH      = 12,
  parameter int LANES        = 8,
  parameter int IDX_BITS_MAX = 9,
  parameter int RADIX_SHIFT  = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start_i,
  input  logic [$clog2(IDX_BITS_MAX+1)-1:0]             cfg_log_n_i,
`ifdef AGU_NAT_ORDER_EN
  input  logic                                          nat_order_i,
`endif
  output logic                                          busy_o,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic [IDX_BITS_MAX-1:0]                       out_j_o,
  output logic                                          out_last_o,
  output logic [LANES*(1<<RADIX_SHIFT)*D_WIDTH-1:0]     order_o,
  output logic                                          done_o
);
  localparam int R  = 1 << RADIX_SHIFT;
  localparam int LB = $clog2(LANES);
  localparam int CW = $clog2(IDX_BITS_MAX+1);
  localparam int IW = IDX_BITS_MAX;
  localparam int OW = LANES*R*D_WIDTH;

  if (IDX_BITS_MAX + RADIX_SHIFT > D_WIDTH) begin : g_width_check
    $error("agu_bitrev_gen: IDX_BITS_MAX + RADIX_SHIFT exceeds D_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [CW-1:0] l_q, l_clamp, l_sel;
  logic [IW-1:0] j_sel, idx, addr;
  logic [OW-1:0] order_nxt;
  logic          last_nxt, nat_sel, accept;
`ifdef AGU_NAT_ORDER_EN
  logic          nat_q;
`endif

  // Reverse the low l bits of x; bits above l come out zero.
  function automatic logic [IW-1:0] rev_l(input logic [IW-1:0] x, input logic [CW-1:0] l);
    logic [IW-1:0] r;
    for (int b = 0; b < IW; b++) r[b] = x[IW-1-b];
    return r >> (IW - int'(l));
  endfunction

  assign accept = (state == RUN) && out_ready_i;

  // Select the config and base index of the beat about to load: fresh from the inputs in IDLE, advanced otherwise.
  always_comb begin
    l_clamp  = (cfg_log_n_i < CW'(LB)) ? CW'(LB) : (cfg_log_n_i > CW'(IW)) ? CW'(IW) : cfg_log_n_i;
    l_sel    = (state == IDLE) ? l_clamp : l_q;
    j_sel    = (state == IDLE) ? '0 : out_j_o + IW'(LANES);
`ifdef AGU_NAT_ORDER_EN
    nat_sel  = (state == IDLE) ? nat_order_i : nat_q;
`else
    nat_sel  = 1'b0;
`endif
    last_nxt = {1'b0, j_sel} == (((IW+1)'(1) << l_sel) - (IW+1)'(LANES));
  end

  // Build every member address of the next beat.
  always_comb begin
    order_nxt = '0;
    idx       = '0;
    addr      = '0;
    for (int i = 0; i < LANES; i++) begin
      idx  = j_sel + IW'(i);
      addr = nat_sel ? idx : rev_l(idx, l_sel);
      for (int m = 0; m < R; m++)
        order_nxt[(i*R+m)*D_WIDTH +: D_WIDTH] = (D_WIDTH'(addr) << RADIX_SHIFT) + D_WIDTH'(m);
    end
  end

  // Run control with registered beat outputs; beat registers move only on load or accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      l_q         <= '0;
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
      out_j_o     <= '0;
      order_o     <= '0;
`ifdef AGU_NAT_ORDER_EN
      nat_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state       <= RUN;
          busy_o      <= 1'b1;
          out_valid_o <= 1'b1;
          l_q         <= l_sel;
`ifdef AGU_NAT_ORDER_EN
          nat_q       <= nat_sel;
`endif
          out_j_o     <= j_sel;
          order_o     <= order_nxt;
          out_last_o  <= last_nxt;
        end
        RUN: if (accept) begin
          if (out_last_o) begin
            state       <= DONE;
            out_valid_o <= 1'b0;
            done_o      <= 1'b1;
          end else begin
            out_j_o    <= j_sel;
            order_o    <= order_nxt;
            out_last_o <= last_nxt;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_agu_bitrev_gen.sv
// tb_agu_bitrev_gen: directed checks of agu_bitrev_gen in the default (bit-reversed) build
module tb_agu_bitrev_gen;
  typedef int vec_t[8];

  logic         clk = 1'b0, rst = 1'b0, start_i = 1'b0, out_ready_i = 1'b1;
  logic [3:0]   cfg_log_n_i = '0;
  logic         busy_o, out_valid_o, out_last_o, done_o;
  logic [8:0]   out_j_o;
  logic [191:0] order_o;
  int           checks = 0, failures = 0;

  agu_bitrev_gen dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_log_n_i(cfg_log_n_i),
    .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_j_o(out_j_o), .out_last_o(out_last_o), .order_o(order_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [191:0] mk(input vec_t v);
    logic [191:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*24 +: 12]      = 12'(2*v[i]);
      r[i*24 + 12 +: 12] = 12'(2*v[i] + 1);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [191:0] e3, e4a, e4b, e5a, e5b, e5c, e5d;

  initial begin
    e3  = mk('{0, 4, 2, 6, 1, 5, 3, 7});
    e4a = mk('{0, 8, 4, 12, 2, 10, 6, 14});
    e4b = mk('{1, 9, 5, 13, 3, 11, 7, 15});
    e5a = mk('{0, 16, 8, 24, 4, 20, 12, 28});
    e5b = mk('{1, 17, 9, 25, 5, 21, 13, 29} );
    e5b = mk('{2, 18, 10, 26, 6, 22, 14, 30});
    e5c = mk('{1, 17, 9, 25, 5, 21, 13, 29});
    e5d = mk('{3, 19, 11, 27, 7, 23, 15, 31});

    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_j", out_j_o, 0);
    chk("rst_order", order_o, 0);
    rst = 1'b1;
    tick();

    cfg_log_n_i = 4'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("l3_valid", out_valid_o, 1);
    chk("l3_busy", busy_o, 1);
    chk("l3_last", out_last_o, 1);
    chk("l3_j", out_j_o, 0);
    chk("l3_order", order_o, e3);
    chk("l3_done_early", done_o, 0);
    tick();
    chk("l3_done", done_o, 1);
    chk("l3_valid_off", out_valid_o, 0);
    chk("l3_busy_done", busy_o, 1);
    tick();
    chk("l3_done_off", done_o, 0);
    chk("l3_idle", busy_o, 0);

    cfg_log_n_i = 4'd4; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("l4_b0_j", out_j_o, 0);
    chk("l4_b0_last", out_last_o, 0);
    chk("l4_b0_order", order_o, e4a);
    tick();
    chk("l4_b1_j", out_j_o, 8);
    chk("l4_b1_last", out_last_o, 1);
    chk("l4_b1_order", order_o, e4b);
    tick();
    chk("l4_done", done_o, 1);
    tick();
    chk("l4_idle", busy_o, 0);

    cfg_log_n_i = 4'd5; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("l5_b0_order", order_o, e5a);
    tick();
    chk("l5_b1_j", out_j_o, 8);
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_i     = (k == 1);
      cfg_log_n_i = (k == 1) ? 4'd3 : 4'd5;
      tick();
      chk("bp_valid", out_valid_o, 1);
      chk("bp_j", out_j_o, 8);
      chk("bp_last", out_last_o, 0);
      chk("bp_order", order_o, e5b);
    end
    start_i = 1'b0; cfg_log_n_i = 4'd5; out_ready_i = 1'b1;
    tick();
    chk("l5_b2_j", out_j_o, 16);
    chk("l5_b2_last", out_last_o, 0);
    chk("l5_b2_order", order_o, e5c);
    tick();
    chk("l5_b3_j", out_j_o, 24);
    chk("l5_b3_last", out_last_o, 1);
    chk("l5_b3_order", order_o, e5d);
    tick();
    chk("l5_done", done_o, 1);
    tick();
    chk("l5_idle", busy_o, 0);

    cfg_log_n_i = 4'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("clamp_last", out_last_o, 1);
    chk("clamp_order", order_o, e3);
    tick();
    chk("clamp_done", done_o, 1);
    tick();

    cfg_log_n_i = 4'd4; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("mr_b1_j", out_j_o, 8);
    rst = 1'b0;
    #1;
    chk("mr_busy", busy_o, 0);
    chk("mr_valid", out_valid_o, 0);
    chk("mr_last", out_last_o, 0);
    chk("mr_j", out_j_o, 0);
    chk("mr_order", order_o, 0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_done", done_o, 0);
      chk("mr_wait_valid", out_valid_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
